// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALUctr encodings, default widths
// and the bundle of EX control bits latched from ID.
package id_ex_stage_pkg;

    localparam int XLEN_DEF = 32;
    localparam int RA_W_DEF = 5;

    localparam logic [3:0] ALUCTR_ADD  = 4'b0000;
    localparam logic [3:0] ALUCTR_ADDU = 4'b0001;
    localparam logic [3:0] ALUCTR_SUB  = 4'b0010;
    localparam logic [3:0] ALUCTR_SUBU = 4'b0011;
    localparam logic [3:0] ALUCTR_AND  = 4'b0100;
    localparam logic [3:0] ALUCTR_OR   = 4'b0101;
    localparam logic [3:0] ALUCTR_XOR  = 4'b0110;
    localparam logic [3:0] ALUCTR_NOR  = 4'b0111;
    localparam logic [3:0] ALUCTR_SLT  = 4'b1010;
    localparam logic [3:0] ALUCTR_SLTU = 4'b1011;
    // A bubble computes addu so the ALU can never raise an overflow trap.
    localparam logic [3:0] ALUCTR_NOP  = ALUCTR_ADDU;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic [3:0] alu_ctr;
    } ex_ctrl_t;

    localparam ex_ctrl_t CTRL_BUBBLE = '{
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        alu_src:    1'b0,
        alu_ctr:    ALUCTR_NOP
    };

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding for one source register: the younger EX/MEM result wins
// over MEM/WB, and register $0 always reads the latched value.
module ex_fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic [XLEN-1:0] data,
    input  logic [RA_W-1:0] src,
    input  logic            exm_reg_write,
    input  logic [RA_W-1:0] exm_wr_reg,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_reg_write,
    input  logic [RA_W-1:0] mwb_wr_reg,
    input  logic [XLEN-1:0] mwb_result,
    output logic [XLEN-1:0] fwd_data
);

    logic exm_hit;
    logic mwb_hit;

    assign exm_hit = exm_reg_write && (exm_wr_reg == src) && (src != '0);
    assign mwb_hit = mwb_reg_write && (mwb_wr_reg == src) && (src != '0);

    always_comb begin
        fwd_data = data;
        if (exm_hit) begin
            fwd_data = exm_result;
        end else if (mwb_hit) begin
            fwd_data = mwb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded fields, forwards ALU operands,
// selects the immediate for B and inserts bubbles on load-use hazards.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs_data,
    input  logic [XLEN-1:0] id_rt_data,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [RA_W-1:0] id_wr_reg,
    input  logic [15:0]     id_imm,
    input  logic            id_ext_op,
    input  logic            id_alu_src,
    input  logic [3:0]      id_alu_ctr,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic            exm_reg_write,
    input  logic [RA_W-1:0] exm_wr_reg,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_reg_write,
    input  logic [RA_W-1:0] mwb_wr_reg,
    input  logic [XLEN-1:0] mwb_result,
    output logic            ld_use_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_a,
    output logic [XLEN-1:0] ex_b,
    output logic [3:0]      ex_alu_ctr,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RA_W-1:0] ex_wr_reg,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg
);

    ex_ctrl_t        ctrl_q;
    ex_ctrl_t        id_ctrl;
    logic [RA_W-1:0] rs_q;
    logic [RA_W-1:0] rt_q;
    logic [XLEN-1:0] rs_data_q;
    logic [XLEN-1:0] rt_data_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] id_ext_imm;
    logic [XLEN-1:0] fwd_rs;
    logic [XLEN-1:0] fwd_rt;
    logic            load_bubble;

    assign id_ctrl = '{
        reg_write:  id_reg_write,
        mem_read:   id_mem_read,
        mem_write:  id_mem_write,
        mem_to_reg: id_mem_to_reg,
        alu_src:    id_alu_src,
        alu_ctr:    id_alu_ctr
    };

    assign id_ext_imm = {{(XLEN-16){id_imm[15] & id_ext_op}}, id_imm};

    // Store data (rt of a store) is not a hazard: MEM/WB forwards it next cycle.
    assign ld_use_stall = !stall && !flush && ex_valid && ctrl_q.mem_read
                          && (ex_wr_reg != '0)
                          && ((ex_wr_reg == id_rs)
                              || ((ex_wr_reg == id_rt) && !id_alu_src && !id_mem_write));

    assign load_bubble = rst || flush || (!stall && (ld_use_stall || !id_valid));

    ex_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs (
        .data          (rs_data_q),
        .src           (rs_q),
        .exm_reg_write (exm_reg_write),
        .exm_wr_reg    (exm_wr_reg),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_wr_reg    (mwb_wr_reg),
        .mwb_result    (mwb_result),
        .fwd_data      (fwd_rs)
    );

    ex_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rt (
        .data          (rt_data_q),
        .src           (rt_q),
        .exm_reg_write (exm_reg_write),
        .exm_wr_reg    (exm_wr_reg),
        .exm_result    (exm_result),
        .mwb_reg_write (mwb_reg_write),
        .mwb_wr_reg    (mwb_wr_reg),
        .mwb_result    (mwb_result),
        .fwd_data      (fwd_rt)
    );

    always_ff @(posedge clk) begin
        if (load_bubble) begin
            ex_valid  <= 1'b0;
            ex_pc     <= '0;
            ex_wr_reg <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            ctrl_q    <= CTRL_BUBBLE;
        end else if (stall) begin
            // Capture forwarded data so a producer retiring from WB mid-stall is kept.
            rs_data_q <= fwd_rs;
            rt_data_q <= fwd_rt;
        end else begin
            ex_valid  <= 1'b1;
            ex_pc     <= id_pc;
            ex_wr_reg <= id_wr_reg;
            rs_q      <= id_rs;
            rt_q      <= id_rt;
            rs_data_q <= id_rs_data;
            rt_data_q <= id_rt_data;
            imm_q     <= id_ext_imm;
            ctrl_q    <= id_ctrl;
        end
    end

    assign ex_a          = fwd_rs;
    assign ex_b          = ctrl_q.alu_src ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_alu_ctr    = ctrl_q.alu_ctr;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table of vectors with hand-derived expectations,
// multi-cycle stall/reset sequences and a randomized pass against a small model.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int W = 142;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, stall, flush, id_valid;
    logic [31:0] id_pc, id_rs_data, id_rt_data;
    logic [4:0] id_rs, id_rt, id_wr_reg;
    logic [15:0] id_imm;
    logic id_ext_op, id_alu_src;
    logic [3:0] id_alu_ctr;
    logic id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic exm_reg_write, mwb_reg_write;
    logic [4:0] exm_wr_reg, mwb_wr_reg;
    logic [31:0] exm_result, mwb_result;
    logic ld_use_stall, ex_valid;
    logic [31:0] ex_pc, ex_a, ex_b, ex_store_data;
    logic [3:0] ex_alu_ctr;
    logic [4:0] ex_wr_reg;
    logic ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_pc(id_pc), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_rs(id_rs), .id_rt(id_rt), .id_wr_reg(id_wr_reg), .id_imm(id_imm),
        .id_ext_op(id_ext_op), .id_alu_src(id_alu_src), .id_alu_ctr(id_alu_ctr),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exm_reg_write(exm_reg_write), .exm_wr_reg(exm_wr_reg), .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_wr_reg(mwb_wr_reg), .mwb_result(mwb_result),
        .ld_use_stall(ld_use_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_a(ex_a), .ex_b(ex_b), .ex_alu_ctr(ex_alu_ctr), .ex_store_data(ex_store_data),
        .ex_wr_reg(ex_wr_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    typedef struct {
        logic rst, stall, flush, id_valid;
        logic [31:0] pc, rsd, rtd;
        logic [4:0] rs, rt, wr;
        logic [15:0] imm;
        logic ext_op, alu_src;
        logic [3:0] ctr;
        logic rw, mr, mw, mtr;
        logic exm_w; logic [4:0] exm_r; logic [31:0] exm_d;
        logic mwb_w; logic [4:0] mwb_r; logic [31:0] mwb_d;
        logic exp_lus;
        logic pre_chk; logic [31:0] pre_a;
        logic [W-1:0] exp;
    } vec_t;

    logic [W-1:0] exp_q[$];
    vec_t tbl[$];
    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] bub;

    function automatic logic [W-1:0] pk(logic v, logic [31:0] pc, logic [31:0] a, logic [31:0] b,
                                        logic [3:0] ctr, logic [31:0] sd, logic [4:0] wr,
                                        logic rw, logic mr, logic mw, logic mtr);
        return {v, pc, a, b, ctr, sd, wr, rw, mr, mw, mtr};
    endfunction

    function automatic vec_t nv();
        vec_t v;
        v.rst = 1'b0; v.stall = 1'b0; v.flush = 1'b0; v.id_valid = 1'b0;
        v.pc = '0; v.rsd = '0; v.rtd = '0; v.rs = '0; v.rt = '0; v.wr = '0;
        v.imm = '0; v.ext_op = 1'b0; v.alu_src = 1'b0; v.ctr = 4'h0;
        v.rw = 1'b0; v.mr = 1'b0; v.mw = 1'b0; v.mtr = 1'b0;
        v.exm_w = 1'b0; v.exm_r = '0; v.exm_d = '0;
        v.mwb_w = 1'b0; v.mwb_r = '0; v.mwb_d = '0;
        v.exp_lus = 1'b0; v.pre_chk = 1'b0; v.pre_a = '0;
        v.exp = pk(1'b0, 32'h0, 32'h0, 32'h0, 4'b0001, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        return v;
    endfunction

    function automatic logic [31:0] model_fwd(vec_t v, logic [4:0] src, logic [31:0] d);
        if (src == 5'd0) return d;
        if (v.exm_w && v.exm_r == src) return v.exm_d;
        if (v.mwb_w && v.mwb_r == src) return v.mwb_d;
        return d;
    endfunction

    function automatic logic [W-1:0] model_exp(vec_t v);
        logic [31:0] ext;
        ext = v.ext_op ? {{16{v.imm[15]}}, v.imm} : {16'h0, v.imm};
        if (!v.id_valid) return bub;
        return pk(1'b1, v.pc, model_fwd(v, v.rs, v.rsd),
                  v.alu_src ? ext : model_fwd(v, v.rt, v.rtd), v.ctr,
                  model_fwd(v, v.rt, v.rtd), v.wr, v.rw, v.mr, v.mw, v.mtr);
    endfunction

    task automatic chk32(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s vec%0d: got %h want %h", name, idx, got, want);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [W-1:0] got;
        logic [W-1:0] want;
        rst = v.rst; stall = v.stall; flush = v.flush; id_valid = v.id_valid;
        id_pc = v.pc; id_rs_data = v.rsd; id_rt_data = v.rtd;
        id_rs = v.rs; id_rt = v.rt; id_wr_reg = v.wr; id_imm = v.imm;
        id_ext_op = v.ext_op; id_alu_src = v.alu_src; id_alu_ctr = v.ctr;
        id_reg_write = v.rw; id_mem_read = v.mr; id_mem_write = v.mw; id_mem_to_reg = v.mtr;
        exm_reg_write = v.exm_w; exm_wr_reg = v.exm_r; exm_result = v.exm_d;
        mwb_reg_write = v.mwb_w; mwb_wr_reg = v.mwb_r; mwb_result = v.mwb_d;
        #1;
        if (!v.rst) chk32("ld_use_stall", idx, {31'h0, ld_use_stall}, {31'h0, v.exp_lus});
        if (v.pre_chk) chk32("ex_a_before_edge", idx, ex_a, v.pre_a);
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        got = {ex_valid, ex_pc, ex_a, ex_b, ex_alu_ctr, ex_store_data, ex_wr_reg,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg};
        want = exp_q.pop_front();
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL stage_out vec%0d: got %h want %h", idx, got, want);
        end
    endtask

    initial begin
        vec_t v;
        vec_t ld5;
        vec_t st;
        bub = pk(1'b0, 32'h0, 32'h0, 32'h0, 4'b0001, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset for two cycles while ID presents a valid instruction.
        v = nv(); v.rst = 1'b1; v.id_valid = 1'b1; v.pc = 32'h40; v.rs = 5'd1; v.rsd = 32'd5;
        v.rw = 1'b1; v.ctr = 4'h0; v.wr = 5'd1;
        apply(v, 0);
        apply(v, 1);

        // addi $2,$1,-4
        v = nv(); v.id_valid = 1'b1; v.pc = 32'h100; v.rs = 5'd1; v.rsd = 32'd10; v.rt = 5'd2;
        v.rtd = 32'h55; v.wr = 5'd2; v.imm = 16'hFFFC; v.ext_op = 1'b1; v.alu_src = 1'b1;
        v.ctr = 4'h0; v.rw = 1'b1;
        v.exp = pk(1'b1, 32'h100, 32'd10, 32'hFFFFFFFC, 4'h0, 32'h55, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl.push_back(v);
        // ori: zero-extension
        v = nv(); v.id_valid = 1'b1; v.pc = 32'h104; v.rs = 5'd3; v.rsd = 32'h1234; v.rt = 5'd4;
        v.rtd = 32'd7; v.wr = 5'd4; v.imm = 16'h8001; v.alu_src = 1'b1; v.ctr = 4'h5; v.rw = 1'b1;
        v.exp = pk(1'b1, 32'h104, 32'h1234, 32'h8001, 4'h5, 32'd7, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl.push_back(v);
        // EX/MEM and MEM/WB both write $3: EX/MEM wins
        v = nv(); v.id_valid = 1'b1; v.pc = 32'h108; v.rs = 5'd3; v.rsd = 32'd1; v.rt = 5'd6;
        v.rtd = 32'd2; v.wr = 5'd7; v.ctr = 4'h2; v.rw = 1'b1;
        v.exm_w = 1'b1; v.exm_r = 5'd3; v.exm_d = 32'd7; v.mwb_w = 1'b1; v.mwb_r = 5'd3; v.mwb_d = 32'd9;
        v.exp = pk(1'b1, 32'h108, 32'd7, 32'd2, 4'h2, 32'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl.push_back(v);
        v.exm_w = 1'b0;
        v.exp = pk(1'b1, 32'h108, 32'd9, 32'd2, 4'h2, 32'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl.push_back(v);
        // $0 is never forwarded
        v = nv(); v.id_valid = 1'b1; v.pc = 32'h10C; v.rsd = 32'h11; v.rtd = 32'h22; v.wr = 5'd8;
        v.ctr = 4'h1; v.rw = 1'b1;
        v.exm_w = 1'b1; v.exm_d = 32'd7; v.mwb_w = 1'b1; v.mwb_d = 32'd9;
        v.exp = pk(1'b1, 32'h10C, 32'h11, 32'h22, 4'h1, 32'h22, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl.push_back(v);
        // rs from EX/MEM, rt from MEM/WB
        v = nv(); v.id_valid = 1'b1; v.pc = 32'h110; v.rs = 5'd5; v.rt = 5'd6; v.rtd = 32'd2;
        v.wr = 5'd9; v.ctr = 4'hB; v.rw = 1'b1;
        v.exm_w = 1'b1; v.exm_r = 5'd5; v.exm_d = 32'd3; v.mwb_w = 1'b1; v.mwb_r = 5'd6; v.mwb_d = 32'hABC;
        v.exp = pk(1'b1, 32'h110, 32'd3, 32'hABC, 4'hB, 32'hABC, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl.push_back(v);
        // id_valid=0 loads a bubble
        v = nv(); v.pc = 32'h114; v.rs = 5'd1; v.rsd = 32'd4; v.rw = 1'b1; v.wr = 5'd3;
        tbl.push_back(v);
        // flush with a valid instruction
        v = tbl[0]; v.flush = 1'b1; v.exp = bub;
        tbl.push_back(v);
        // lw $5 then dependent add: one bubble, then the add loads
        ld5 = nv(); ld5.id_valid = 1'b1; ld5.pc = 32'h120; ld5.rs = 5'd1; ld5.rsd = 32'h1000;
        ld5.rt = 5'd5; ld5.imm = 16'd4; ld5.ext_op = 1'b1; ld5.alu_src = 1'b1; ld5.wr = 5'd5;
        ld5.rw = 1'b1; ld5.mr = 1'b1; ld5.mtr = 1'b1;
        ld5.exp = pk(1'b1, 32'h120, 32'h1000, 32'd4, 4'h0, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        tbl.push_back(ld5);
        v = nv(); v.id_valid = 1'b1; v.pc = 32'h124; v.rs = 5'd5; v.rsd = 32'h20; v.rt = 5'd6;
        v.rtd = 32'h30; v.wr = 5'd8; v.rw = 1'b1; v.exp_lus = 1'b1;
        tbl.push_back(v);
        v.exp_lus = 1'b0; v.mwb_w = 1'b1; v.mwb_r = 5'd5; v.mwb_d = 32'h77;
        v.exp = pk(1'b1, 32'h124, 32'h77, 32'h30, 4'h0, 32'h30, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl.push_back(v);
        // lw $5 then sw using $5 only as store data: no stall
        ld5.pc = 32'h128;
        ld5.exp = pk(1'b1, 32'h128, 32'h1000, 32'd4, 4'h0, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
        tbl.push_back(ld5);
        st = nv(); st.id_valid = 1'b1; st.pc = 32'h12C; st.rs = 5'd1; st.rsd = 32'h2000; st.rt = 5'd5;
        st.imm = 16'd8; st.ext_op = 1'b1; st.alu_src = 1'b1; st.mw = 1'b1;
        st.mwb_w = 1'b1; st.mwb_r = 5'd5; st.mwb_d = 32'h88;
        st.exp = pk(1'b1, 32'h12C, 32'h2000, 32'd8, 4'h0, 32'h88, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tbl.push_back(st);
        // lw $0 never causes a stall
        v = nv(); v.id_valid = 1'b1; v.pc = 32'h130; v.rs = 5'd1; v.rsd = 32'd4; v.ext_op = 1'b1;
        v.alu_src = 1'b1; v.rw = 1'b1; v.mr = 1'b1; v.mtr = 1'b1;
        v.exp = pk(1'b1, 32'h130, 32'd4, 32'h0, 4'h0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        tbl.push_back(v);
        v = nv(); v.id_valid = 1'b1; v.pc = 32'h134; v.rsd = 32'd5; v.rtd = 32'd6; v.wr = 5'd9; v.rw = 1'b1;
        v.exp = pk(1'b1, 32'h134, 32'd5, 32'd6, 4'h0, 32'd6, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl.push_back(v);
        // lw $7 then ALU use of $7 through rt
        v = nv(); v.id_valid = 1'b1; v.pc = 32'h138; v.rs = 5'd1; v.rsd = 32'h10; v.rt = 5'd7;
        v.ext_op = 1'b1; v.alu_src = 1'b1; v.wr = 5'd7; v.rw = 1'b1; v.mr = 1'b1; v.mtr = 1'b1;
        v.exp = pk(1'b1, 32'h138, 32'h10, 32'h0, 4'h0, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        tbl.push_back(v);
        v = nv(); v.id_valid = 1'b1; v.pc = 32'h13C; v.rs = 5'd2; v.rsd = 32'd1; v.rt = 5'd7;
        v.rtd = 32'd2; v.wr = 5'd3; v.rw = 1'b1; v.exp_lus = 1'b1;
        tbl.push_back(v);
        // unlisted ALUctr passes through
        v = nv(); v.id_valid = 1'b1; v.pc = 32'h140; v.rs = 5'd1; v.rsd = 32'd3; v.rt = 5'd2;
        v.rtd = 32'd4; v.ctr = 4'hF; v.wr = 5'd3; v.rw = 1'b1;
        v.exp = pk(1'b1, 32'h140, 32'd3, 32'd4, 4'hF, 32'd4, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tbl.push_back(v);
        // stall and flush together: flush wins
        v = tbl[0]; v.stall = 1'b1; v.flush = 1'b1; v.exp = bub;
        tbl.push_back(v);

        foreach (tbl[i]) apply(tbl[i], 10 + i);

        // Multi-cycle stall with a MEM/WB producer only in the first stall cycle.
        v = nv(); v.id_valid = 1'b1; v.pc = 32'h200; v.rs = 5'd4; v.rsd = 32'd1; v.rt = 5'd6;
        v.rtd = 32'd2; v.ctr = 4'h4; v.wr = 5'd10; v.rw = 1'b1; v.mr = 1'b1; v.mtr = 1'b1;
        v.exp = pk(1'b1, 32'h200, 32'd1, 32'd2, 4'h4, 32'd2, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
        apply(v, 50);
        v = nv(); v.stall = 1'b1; v.id_valid = 1'b1; v.pc = 32'h204; v.rs = 5'd10; v.rt = 5'd11;
        v.rw = 1'b1; v.wr = 5'd12; v.mwb_w = 1'b1; v.mwb_r = 5'd4; v.mwb_d = 32'd42;
        v.exp = pk(1'b1, 32'h200, 32'd42, 32'd2, 4'h4, 32'd2, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1);
        apply(v, 51);
        v.mwb_w = 1'b0; v.mwb_d = 32'd0;
        apply(v, 52);
        apply(v, 53);
        // Release: EX still shows 42, and the waiting instruction hits the load.
        v.stall = 1'b0; v.exp_lus = 1'b1; v.pre_chk = 1'b1; v.pre_a = 32'd42; v.exp = bub;
        apply(v, 54);

        // Reset while stalled yields a bubble; a stalled bubble stays a bubble.
        v = nv(); v.id_valid = 1'b1; v.pc = 32'h300; v.rs = 5'd4; v.rsd = 32'd1; v.rt = 5'd6;
        v.rtd = 32'd2; v.ctr = 4'h4; v.wr = 5'd10; v.rw = 1'b1;
        v.exp = pk(1'b1, 32'h300, 32'd1, 32'd2, 4'h4, 32'd2, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(v, 60);
        v.rst = 1'b1; v.stall = 1'b1; v.exp = bub;
        apply(v, 61);
        v.rst = 1'b0;
        apply(v, 62);

        // Randomized traffic without loads, checked against the model.
        for (int i = 0; i < 40; i++) begin
            v = nv();
            v.id_valid = ($urandom_range(0, 3) != 0);
            v.pc = $urandom; v.rsd = $urandom; v.rtd = $urandom;
            v.rs = 5'($urandom_range(0, 7)); v.rt = 5'($urandom_range(0, 7));
            v.wr = 5'($urandom_range(0, 31)); v.imm = 16'($urandom_range(0, 65535));
            v.ext_op = 1'($urandom_range(0, 1)); v.alu_src = 1'($urandom_range(0, 1));
            v.ctr = 4'($urandom_range(0, 15)); v.rw = 1'($urandom_range(0, 1));
            v.mw = 1'($urandom_range(0, 1)); v.mtr = 1'($urandom_range(0, 1));
            v.exm_w = 1'($urandom_range(0, 1)); v.exm_r = 5'($urandom_range(0, 7)); v.exm_d = $urandom;
            v.mwb_w = 1'($urandom_range(0, 1)); v.mwb_r = 5'($urandom_range(0, 7)); v.mwb_d = $urandom;
            v.exp = model_exp(v);
            apply(v, 100 + i);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
